// File: rtl/lane_queue_sensor.sv
// Per-lane loop detector front end: synchronise, debounce, count vehicles, drain on green, emit congestion code.
// Optional stuck-detector supervision is compiled in with `define LANE_STUCK_DETECT_EN.
module lane_queue_sensor #(
   parameter int DEBOUNCE_CYCLES  = 3,
   parameter int Q_W              = 5,
   parameter int LOW_THRESH       = 4,
   parameter int HIGH_THRESH      = 10,
   parameter int DISCHARGE_CYCLES = 8,
   parameter int STUCK_CYCLES     = 64
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           loop_raw_i,
   input  logic [2:0]     light_state_i,
   output logic [1:0]     sensor_code_o,
   output logic [Q_W-1:0] queue_count_o,
   output logic           fault_o
);

   localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int DIS_W = $clog2(DISCHARGE_CYCLES + 1);
   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DIS_W-1:0] DIS_LAST = DIS_W'(DISCHARGE_CYCLES - 1);
   localparam logic [Q_W-1:0]   Q_MAX    = {Q_W{1'b1}};
   localparam logic [Q_W-1:0]   LOW_TH   = Q_W'(LOW_THRESH);
   localparam logic [Q_W-1:0]   HIGH_TH  = Q_W'(HIGH_THRESH);

   logic             sync1_q, sync_q;
   logic             filt_q, filt_d, filt_prev_q;
   logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
   logic [DIS_W-1:0] dis_cnt_q, dis_cnt_d;
   logic [Q_W-1:0]   queue_q, queue_d;
   logic [1:0]       code_q, code_d;
   logic             frozen_s, force_s, arrive_s, depart_s, run_s;

   function automatic logic [1:0] thermo_code(input logic [Q_W-1:0] q);
      if (q >= HIGH_TH) begin
         return 2'b11;
      end else if (q >= LOW_TH) begin
         return 2'b01;
      end else begin
         return 2'b00;
      end
   endfunction

   // Debounce: filtered level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
   always_comb begin
      filt_d   = filt_q;
      db_cnt_d = {DB_W{1'b0}};
      if (sync_q != filt_q) begin
         if (db_cnt_q == DB_LAST) begin
            filt_d   = ~filt_q;
            db_cnt_d = {DB_W{1'b0}};
         end else begin
            db_cnt_d = db_cnt_q + 1'b1;
         end
      end else begin
         db_cnt_d = {DB_W{1'b0}};
      end
   end

   // Queue bookkeeping: arrivals on filtered rise, departures after each full green interval.
   always_comb begin
      arrive_s  = filt_q & ~filt_prev_q & ~frozen_s;
      run_s     = (light_state_i == 3'b001) & (queue_q != {Q_W{1'b0}}) & ~frozen_s;
      depart_s  = 1'b0;
      dis_cnt_d = {DIS_W{1'b0}};
      if (run_s) begin
         if (dis_cnt_q == DIS_LAST) begin
            depart_s  = 1'b1;
            dis_cnt_d = {DIS_W{1'b0}};
         end else begin
            dis_cnt_d = dis_cnt_q + 1'b1;
         end
      end else begin
         dis_cnt_d = {DIS_W{1'b0}};
      end
      case ({arrive_s, depart_s})
         2'b10:   queue_d = (queue_q == Q_MAX) ? queue_q : queue_q + 1'b1;
         2'b01:   queue_d = queue_q - 1'b1;
         default: queue_d = queue_q;
      endcase
   end

   // Congestion code trails queue_count by one edge; a stuck fault pins it high.
   always_comb begin
      if (force_s) begin
         code_d = 2'b11;
      end else begin
         code_d = thermo_code(queue_q);
      end
   end

   // Main state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q     <= 1'b0;
         sync_q      <= 1'b0;
         filt_q      <= 1'b0;
         filt_prev_q <= 1'b0;
         db_cnt_q    <= {DB_W{1'b0}};
         dis_cnt_q   <= {DIS_W{1'b0}};
         queue_q     <= {Q_W{1'b0}};
         code_q      <= 2'b00;
      end else begin
         sync1_q     <= loop_raw_i;
         sync_q      <= sync1_q;
         filt_q      <= filt_d;
         filt_prev_q <= filt_q;
         db_cnt_q    <= db_cnt_d;
         dis_cnt_q   <= dis_cnt_d;
         queue_q     <= queue_d;
         code_q      <= code_d;
      end
   end

`ifdef LANE_STUCK_DETECT_EN
   localparam int ST_W = $clog2(STUCK_CYCLES + 1);
   localparam logic [ST_W-1:0] ST_MAX = ST_W'(STUCK_CYCLES);

   logic [ST_W-1:0] stuck_cnt_q, stuck_cnt_d;
   logic            fault_q, fault_d;

   // Stuck supervision: fault latches after STUCK_CYCLES of continuous occupancy, drops with the level.
   always_comb begin
      if (filt_q) begin
         if (stuck_cnt_q == ST_MAX) begin
            stuck_cnt_d = stuck_cnt_q;
         end else begin
            stuck_cnt_d = stuck_cnt_q + 1'b1;
         end
      end else begin
         stuck_cnt_d = {ST_W{1'b0}};
      end
      fault_d = filt_q & (fault_q | (stuck_cnt_q == ST_MAX));
   end

   // Stuck supervision registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stuck_cnt_q <= {ST_W{1'b0}};
         fault_q     <= 1'b0;
      end else begin
         stuck_cnt_q <= stuck_cnt_d;
         fault_q     <= fault_d;
      end
   end

   assign frozen_s = fault_q;
   assign force_s  = fault_d;
   assign fault_o  = fault_q;
`else
   assign frozen_s = 1'b0;
   assign force_s  = 1'b0;
   assign fault_o  = 1'b0;
`endif

   assign sensor_code_o = code_q;
   assign queue_count_o = queue_q;

endmodule

// File: tb/tb_lane_queue_sensor.sv
// Directed bench for lane_queue_sensor with an expectation scoreboard.
module tb_lane_queue_sensor;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       loop_raw;
   logic [2:0] light;
   logic [1:0] code;
   logic [4:0] qcnt;
   logic       flt;

   int total = 0;
   int bad   = 0;
   int exp_q = 0;

   typedef struct {
      string      tag;
      logic [4:0] q;
      logic [1:0] code;
      logic       flt;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   lane_queue_sensor dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .loop_raw_i    (loop_raw),
      .light_state_i (light),
      .sensor_code_o (code),
      .queue_count_o (qcnt),
      .fault_o       (flt)
   );

   function automatic int code_of(input int v);
      if (v >= 10) return 3;
      else if (v >= 4) return 1;
      else return 0;
   endfunction

   task automatic push(input string tag, input int eq, input int ec, input int ef);
      exp_t e;
      e.tag  = tag;
      e.q    = 5'(eq);
      e.code = 2'(ec);
      e.flt  = 1'(ef);
      sb.push_back(e);
   endtask

   task automatic pop_check();
      exp_t e;
      if (sb.size() == 0) begin
         total++;
         bad++;
         $error("FAIL scoreboard_empty got 0 entries want 1");
      end else begin
         e = sb.pop_front();
         total += 3;
         assert (qcnt === e.q) else begin
            bad++;
            $error("FAIL %s queue_count got %0d want %0d", e.tag, qcnt, e.q);
         end
         assert (code === e.code) else begin
            bad++;
            $error("FAIL %s sensor_code got %b want %b", e.tag, code, e.code);
         end
         assert (flt === e.flt) else begin
            bad++;
            $error("FAIL %s fault got %b want %b", e.tag, flt, e.flt);
         end
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic mid_reset();
      #2 rst_n = 1'b0;
      push("reset", 0, 0, 0);
      #1 pop_check();
      step(1);
      rst_n = 1'b1;
      exp_q = 0;
   endtask

   // one clean 5-cycle vehicle with the light red; checks the edge-5/6/7 latency
   task automatic arrive();
      int qb;
      int qa;
      qb = exp_q;
      qa = (exp_q < 31) ? exp_q + 1 : 31;
      push("arr_e5", qb, code_of(qb), 0);
      push("arr_e6", qa, code_of(qb), 0);
      push("arr_e7", qa, code_of(qa), 0);
      loop_raw = 1'b1;
      step(5);
      pop_check();
      loop_raw = 1'b0;
      step(1);
      pop_check();
      step(1);
      pop_check();
      step(5);
      exp_q = qa;
   endtask

   initial begin
      rst_n    = 1'b1;
      loop_raw = 1'b0;
      light    = 3'b100;
      step(1);
      mid_reset();

      push("idle20", 0, 0, 0);
      step(20);
      pop_check();

      for (int i = 0; i < 10; i++) begin
         loop_raw = 1'b1;
         step(2);
         loop_raw = 1'b0;
         step(4);
      end
      push("glitch", 0, 0, 0);
      pop_check();

      for (int i = 0; i < 7; i++) arrive();
      push("q7", 7, 1, 0);
      pop_check();
      mid_reset();

      for (int i = 0; i < 40; i++) arrive();
      push("sat", 31, 3, 0);
      pop_check();

      mid_reset();
      for (int i = 0; i < 10; i++) arrive();
      light = 3'b001;
      for (int k = 1; k <= 80; k++) begin
         int nc;
         nc = code_of(exp_q);
         if (k % 8 == 0) exp_q--;
         push($sformatf("dis%0d", k), exp_q, nc, 0);
         step(1);
         pop_check();
      end
      light = 3'b100;
      step(2);
      push("dis_end", 0, 0, 0);
      pop_check();

      for (int i = 0; i < 3; i++) arrive();
      light = 3'b001;
      step(5);
      light = 3'b010;
      step(1);
      light = 3'b001;
      step(5);
      light = 3'b100;
      step(1);
      push("partial", 3, 0, 0);
      pop_check();

      arrive();
      arrive();
      light = 3'b001;
      step(2);
      loop_raw = 1'b1;
      push("sim7", 5, 1, 0);
      step(5);
      pop_check();
      loop_raw = 1'b0;
      push("sim8", 5, 1, 0);
      step(1);
      pop_check();
      light = 3'b100;
      step(6);
      push("sim_end", 5, 1, 0);
      pop_check();

      mid_reset();
      loop_raw = 1'b1;
      step(100);
`ifdef LANE_STUCK_DETECT_EN
      push("stuck", 1, 3, 1);
`else
      push("stuck", 1, 0, 0);
`endif
      pop_check();
      loop_raw = 1'b0;
      step(10);
      push("release", 1, 0, 0);
      pop_check();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
